lifo_drain_packer: RTL
======================

# lifo_drain_packer

Downstream stage of the luggage LIFO controller. Captures popped LIFO words, framing strobes (`done_thing`, `done_lifo`) and the zero-substitution flag. Writes them as tagged entries into an internal FIFO. Drains the FIFO onto a ready/valid output stream. The LIFO controller cannot be stalled, so the block absorbs bursts and flags overflow instead of back-pressuring.

## Interface
- `DATA_WIDTH`, 8: data word width.
- `THING_WIDTH`, 4: per-passenger item counter width.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 4.
- `SEPSIGN`, 8'h3b: byte emitted for end of passenger.
- `ENDSIGN`, 8'h24: byte emitted for end of stream.
- `ZERO_CHAR`, 8'h30: byte emitted for an empty passenger.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk`  in  1  clock, posedge.
- `reset`  in  1  synchronous reset, active high.
- `valid_lifo`  in  1  `lifo_data` is a popped item this cycle.
- `lifo_data`  in  DATA_WIDTH  popped LIFO word.
- `output_zero`  in  1  passenger had no items (level).
- `done_thing`  in  1  passenger finished (level; rising edge counts).
- `done_lifo`  in  1  stream finished (level; rising edge counts).
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_valid`  out  1  output entry available.
- `out_data`  out  DATA_WIDTH  item byte, SEPSIGN, ENDSIGN or ZERO_CHAR.
- `out_sep`  out  1  current entry is a SEPSIGN marker.
- `out_last`  out  1  current entry is the ENDSIGN marker.
- `out_count`  out  THING_WIDTH  on a SEPSIGN entry: items in that passenger; 0 otherwise.
- `overflow`  out  1  sticky; at least one entry was dropped.
- `done_out`  out  1  ENDSIGN accepted downstream; held.

## Operation
- **Edge detection.** Registered copies `done_thing_d` and `done_lifo_d`. An event is `x & ~x_d`.
- **Item writes.** In RUN, `valid_lifo=1` writes one data entry.
  - If `output_zero=1` in the same cycle, the entry is ZERO_CHAR and is not counted.
  - Otherwise the entry is `lifo_data` and the passenger counter increments, saturating at all-ones.
- **Zero entry dedupe.** Only one ZERO_CHAR entry is written per passenger, and it is not duplicated when `output_zero` persists.
  - An `output_zero` rising edge with `valid_lifo=0` writes ZERO_CHAR once.
  - A ZERO_CHAR already written for this passenger suppresses further ZERO_CHAR writes.
- **Passenger end.** A `done_thing` event writes a SEPSIGN entry tagged with the counter value. The counter and the zero-written flag then clear.
- **Stream end.** A `done_lifo` event writes an ENDSIGN entry and moves the FSM to FLUSH.
- **Write ordering.** Up to 3 writes per cycle, in the order data, SEPSIGN, ENDSIGN, into consecutive slots. The FIFO needs a 3-wide write port with a per-slot free check.
- **Overflow.** Any write that finds no free slot is dropped and sets `overflow`. Lower-order writes in the same cycle still land if they fit.
- **FSM:**
  - RUN → FLUSH on a `done_lifo` event.
  - FLUSH: inputs ignored; → DONE when the ENDSIGN entry is accepted (`out_valid & out_ready & out_last`).
  - DONE: `done_out=1`, inputs ignored, held until reset.
- **Arithmetic.** FIFO pointers are log2(DEPTH)+1 bits; `full` and `empty` come from MSB compare. Occupancy is never negative.

## Timing
- **Reset values.** All outputs 0, FIFO empty, state RUN, counter 0, edge registers 0.
- **Reset mid-operation.** Discards FIFO contents and clears `overflow` and `done_out` on the next edge.
- **Latency.** An entry written at edge N is visible on `out_*` after edge N (one-cycle write-to-read latency). With an empty FIFO and `out_ready=1`, the entry is consumed at edge N+1.
- **Output stream rules.**
  - `out_valid = ~empty`.
  - `out_data`, `out_sep`, `out_last` and `out_count` are stable while `out_valid & ~out_ready`.
  - A pop occurs on `out_valid & out_ready`.
- **Simultaneous pop and write.**
  - A pop frees its slot for writes in the same cycle; full-plus-pop accepts one write.
  - Same-cycle read and write on an empty FIFO is not possible; the entry appears next cycle.
- **Sustained rate.** One entry per cycle.

## Structure
- Shared package `luggage_pkg`:
  - SEPSIGN, ENDSIGN, ZERO_CHAR constants.
  - Entry-tag enum: DATA, ZERO, SEP, END.
  - Packed entry struct: tag, data, count.
  - FSM state enum: RUN, FLUSH, DONE.
- One sub-module, `tagged_fifo`: DEPTH entries, 3-wide write port, single read port, full/empty flags, drop reporting.
- The top holds the edge detectors, passenger counter, FSM and output mapping.

## Test plan
- **Two items then SEP.**
  - Stimulus: `valid_lifo` with 8'h41, then with 8'h42 alongside a `done_thing` edge; `out_ready=1`.
  - Required: outputs 41, 42, 3b; `out_sep=1` with `out_count=2` on the 3b.
- **Empty passenger.**
  - Stimulus: `output_zero` high for 2 cycles with `valid_lifo=1` on the second cycle, then a `done_thing` edge.
  - Required: exactly one 30, then 3b with `out_count=0`.
- **End of stream.**
  - Stimulus: `done_lifo` edge after one passenger; `out_ready` low for 5 cycles, then high.
  - Required: 24 is held stable with `out_last=1`; `done_out` rises the cycle after acceptance; later inputs are ignored.
- **Overflow.**
  - Stimulus: DEPTH=16, `out_ready=0`, 18 data writes.
  - Required: the first 16 entries are kept; `overflow` is set at write 17; draining returns items 1–16 in order.
- **Full with simultaneous pop.**
  - Stimulus: full FIFO, `out_ready=1` and `valid_lifo` with 8'h5a in the same cycle.
  - Required: 5a is accepted; `overflow` stays 0.
- **Reset in FLUSH.**
  - Stimulus: 3 entries pending, then reset asserted.
  - Required: next cycle `out_valid=0`, `done_out=0`, state RUN; a new item is output normally.

Source files
------------

// File: rtl/luggage_pkg.sv
// Shared types and marker bytes for the luggage LIFO drain path.
// Entry format: the tag selects the emitted byte, and data/count carry item or SEP payload.
package luggage_pkg;

  localparam int ENTRY_DATA_W  = 8;
  localparam int ENTRY_COUNT_W = 4;

  localparam logic [7:0] LUGGAGE_SEPSIGN   = 8'h3b;
  localparam logic [7:0] LUGGAGE_ENDSIGN   = 8'h24;
  localparam logic [7:0] LUGGAGE_ZERO_CHAR = 8'h30;

  typedef enum logic [1:0] {
    TAG_DATA,
    TAG_ZERO,
    TAG_SEP,
    TAG_END
  } entry_tag_e;

  // Field widths match the packer's default DATA_WIDTH/THING_WIDTH.
  typedef struct packed {
    entry_tag_e                 tag;
    logic [ENTRY_DATA_W-1:0]    data;
    logic [ENTRY_COUNT_W-1:0]   count;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lifo_drain_packer_if.sv
// Bundle between the LIFO controller / consumer and the drain packer.
// The slave modport is the packer's view; the master modport is the environment's view.
interface lifo_drain_packer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int THING_WIDTH = 4
);
  logic                   valid_lifo;
  logic [DATA_WIDTH-1:0]  lifo_data;
  logic                   output_zero;
  logic                   done_thing;
  logic                   done_lifo;
  logic                   out_ready;
  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_sep;
  logic                   out_last;
  logic [THING_WIDTH-1:0] out_count;
  logic                   overflow;
  logic                   done_out;

  modport master (
    output valid_lifo, lifo_data, output_zero, done_thing, done_lifo, out_ready,
    input  out_valid, out_data, out_sep, out_last, out_count, overflow, done_out
  );

  modport slave (
    input  valid_lifo, lifo_data, output_zero, done_thing, done_lifo, out_ready,
    output out_valid, out_data, out_sep, out_last, out_count, overflow, done_out
  );
endinterface

// File: rtl/lifo_drain_packer_tagged_fifo.sv
// Tagged-entry FIFO with a multi-slot write port (written in port order) and one show-ahead read port.
// Writes that find no free slot are dropped and reported; a same-cycle pop frees a slot.
module tagged_fifo
  import luggage_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WR_PORTS-1:0] wr_req,
  input  entry_t              wr_entry [WR_PORTS],
  input  logic                rd_en,
  output entry_t              rd_entry,
  output logic                empty,
  output logic                drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   used;
  logic [PW-1:0]   free_cnt;
  logic [PW-1:0]   wr_total;
  logic [PW-1:0]   wr_off [WR_PORTS];
  logic [AW-1:0]   wr_addr [WR_PORTS];
  logic [WR_PORTS-1:0] wr_ok;
  logic            full;
  logic            pop;

  assign used     = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop      = rd_en & ~empty;
  // When full, only the departing head entry makes room this cycle.
  assign free_cnt = full ? PW'(pop) : PW'(DEPTH) - used + PW'(pop);
  assign rd_entry = mem[rd_ptr_reg[AW-1:0]];
  assign drop     = |(wr_req & ~wr_ok);

  always_comb begin
    wr_total = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      wr_off[i] = wr_total;
      wr_ok[i]  = wr_req[i] && (wr_total < free_cnt);
      if (wr_ok[i]) begin
        wr_total = wr_total + PW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_addr
    assign wr_addr[gi] = AW'(wr_ptr_reg + wr_off[gi]);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (wr_ok[i]) begin
        mem[wr_addr[i]] <= wr_entry[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + wr_total;
      rd_ptr_reg <= rd_ptr_reg + PW'(pop);
    end
  end

endmodule

// File: rtl/lifo_drain_packer.sv
// Drain stage of the luggage LIFO controller: turns popped words and framing strobes into a
// tagged entry stream, buffers bursts in a FIFO, and flags drops instead of back-pressuring.
module lifo_drain_packer
  import luggage_pkg::*;
#(
  parameter int                    DATA_WIDTH  = ENTRY_DATA_W,
  parameter int                    THING_WIDTH = ENTRY_COUNT_W,
  parameter int                    DEPTH       = 16,
  parameter logic [DATA_WIDTH-1:0] SEPSIGN     = LUGGAGE_SEPSIGN,
  parameter logic [DATA_WIDTH-1:0] ENDSIGN     = LUGGAGE_ENDSIGN,
  parameter logic [DATA_WIDTH-1:0] ZERO_CHAR   = LUGGAGE_ZERO_CHAR
) (
  input  logic                clk,
  input  logic                reset,
  lifo_drain_packer_if.slave  bus
);
  state_e                 state_reg;
  logic                   done_thing_d_reg;
  logic                   done_lifo_d_reg;
  logic                   output_zero_d_reg;
  logic                   zero_written_reg;
  logic [THING_WIDTH-1:0] count_reg;
  logic                   overflow_reg;
  logic                   done_out_reg;

  logic                   run;
  logic                   thing_evt;
  logic                   lifo_evt;
  logic                   item_req;
  logic                   zero_req;
  logic [THING_WIDTH-1:0] count_next;
  logic [2:0]             wr_req;
  entry_t                 wr_entry [3];
  entry_t                 head;
  logic                   empty;
  logic                   drop;
  logic                   pop;

  logic [DATA_WIDTH-1:0]  out_data_c;
  logic                   out_sep_c;
  logic                   out_last_c;
  logic [THING_WIDTH-1:0] out_count_c;

  always_comb begin
    run        = (state_reg == ST_RUN);
    thing_evt  = run & bus.done_thing & ~done_thing_d_reg;
    lifo_evt   = run & bus.done_lifo & ~done_lifo_d_reg;
    item_req   = run & bus.valid_lifo & ~bus.output_zero;
    // One ZERO_CHAR per passenger: from a popped word while empty, or from the flag's rising edge.
    zero_req   = run & bus.output_zero & (bus.valid_lifo | ~output_zero_d_reg) & ~zero_written_reg;
    count_next = (item_req && (count_reg != '1)) ? count_reg + THING_WIDTH'(1) : count_reg;

    wr_req = {lifo_evt, thing_evt, item_req | zero_req};

    wr_entry[0].tag   = zero_req ? TAG_ZERO : TAG_DATA;
    wr_entry[0].data  = zero_req ? '0 : bus.lifo_data;
    wr_entry[0].count = '0;
    wr_entry[1].tag   = TAG_SEP;
    wr_entry[1].data  = '0;
    wr_entry[1].count = count_next;
    wr_entry[2].tag   = TAG_END;
    wr_entry[2].data  = '0;
    wr_entry[2].count = '0;
  end

  assign pop = bus.out_ready & ~empty;

  tagged_fifo #(
    .DEPTH    (DEPTH),
    .WR_PORTS (3)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_req   (wr_req),
    .wr_entry (wr_entry),
    .rd_en    (bus.out_ready),
    .rd_entry (head),
    .empty    (empty),
    .drop     (drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_RUN;
      done_thing_d_reg  <= 1'b0;
      done_lifo_d_reg   <= 1'b0;
      output_zero_d_reg <= 1'b0;
      zero_written_reg  <= 1'b0;
      count_reg         <= '0;
      overflow_reg      <= 1'b0;
      done_out_reg      <= 1'b0;
    end else begin
      done_thing_d_reg  <= bus.done_thing;
      done_lifo_d_reg   <= bus.done_lifo;
      output_zero_d_reg <= bus.output_zero;
      overflow_reg      <= overflow_reg | drop;
      case (state_reg)
        ST_RUN: begin
          if (thing_evt) begin
            count_reg        <= '0;
            zero_written_reg <= 1'b0;
          end else begin
            count_reg <= count_next;
            if (zero_req) begin
              zero_written_reg <= 1'b1;
            end
          end
          if (lifo_evt) begin
            state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (pop && (head.tag == TAG_END)) begin
            state_reg    <= ST_DONE;
            done_out_reg <= 1'b1;
          end
        end
        default: begin
          done_out_reg <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    out_data_c  = '0;
    out_sep_c   = 1'b0;
    out_last_c  = 1'b0;
    out_count_c = '0;
    if (!empty) begin
      case (head.tag)
        TAG_DATA: out_data_c = head.data;
        TAG_ZERO: out_data_c = ZERO_CHAR;
        TAG_SEP: begin
          out_data_c  = SEPSIGN;
          out_sep_c   = 1'b1;
          out_count_c = head.count;
        end
        default: begin
          out_data_c = ENDSIGN;
          out_last_c = 1'b1;
        end
      endcase
    end
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = out_data_c;
  assign bus.out_sep   = out_sep_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_count = out_count_c;
  assign bus.overflow  = overflow_reg;
  assign bus.done_out  = done_out_reg;

endmodule
